butterfly_addsub: RTL and testbench
===================================

BUTTERFLY_ADDSUB -- requirements
Module: butterfly_addsub

Interface
REQ-001 SHALL have parameter datalength, default 8, giving the signed sample width (Q1.(datalength-1)).
REQ-002 SHALL have parameter SCALE, default 0; 1 = halve both outputs (arithmetic shift right by 1), 0 = saturate.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port EN, input, 1, start of one butterfly operation.
REQ-006 SHALL have port a, input signed, datalength, upper butterfly input.
REQ-007 SHALL have port z, input signed, datalength, twiddle product from the multiplier stage.
REQ-008 SHALL have port ready_product, input, 1, multiplier product valid.
REQ-009 SHALL have port cycle_finish, output, 1, release pulse back to the multiplier stage.
REQ-010 SHALL have port ack, input, 1, downstream has consumed the outputs.
REQ-011 SHALL have port x_sum, output signed, datalength, a + z result.
REQ-012 SHALL have port x_diff, output signed, datalength, a - z result.
REQ-013 SHALL have port valid_out, output, 1, x_sum/x_diff valid.
REQ-014 SHALL have port ovf, output, 1, sticky saturation flag.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_PROD, CALC, OUTPUT.
REQ-016 IDLE: on EN=1 at a clock edge, SHALL latch a into an internal register and move to WAIT_PROD; EN=0 stays IDLE.
REQ-017 WAIT_PROD: on ready_product=1, SHALL latch z and move to CALC; otherwise SHALL hold indefinitely.
REQ-018 CALC: SHALL drive cycle_finish=1 for exactly this one cycle, register x_sum/x_diff and move to OUTPUT at the next edge.
REQ-019 cycle_finish SHALL be 0 in every state other than CALC.
REQ-020 OUTPUT: valid_out SHALL be 1; x_sum/x_diff SHALL hold stable; on ack=1 SHALL return to IDLE with valid_out=0 next cycle.
REQ-021 Latency: ready_product sampled high -> valid_out high exactly 2 clock edges later.
REQ-022 EN SHALL be ignored in WAIT_PROD, CALC, OUTPUT; ready_product SHALL be ignored outside WAIT_PROD; ack SHALL be ignored outside OUTPUT.
REQ-023 Arithmetic SHALL use datalength+1-bit signed sum and difference of the latched a and z.
REQ-024 SCALE=0: results SHALL saturate to [-2^(datalength-1), 2^(datalength-1)-1]; any saturation of either result SHALL set ovf.
REQ-025 SCALE=1: outputs SHALL be the (datalength+1)-bit result arithmetically shifted right by 1 (truncation toward -inf); ovf SHALL never set.
REQ-026 ovf SHALL remain 1 until reset once set.
REQ-027 x_sum/x_diff SHALL change only on the CALC->OUTPUT edge.

Reset
REQ-028 rst=1 SHALL immediately, independent of clk, force state IDLE and x_sum=0, x_diff=0, valid_out=0, cycle_finish=0, ovf=0, latched a/z=0.
REQ-029 Reset asserted mid-operation (any state) SHALL abandon the operation; no cycle_finish or valid_out pulse SHALL follow deassertion.
REQ-030 After rst deasserts, the first EN SHALL be accepted at the next rising edge.

Verification (datalength=8)
REQ-031 SCALE=0, EN with a=20, ready_product with z=10 -> cycle_finish 1 cycle, then x_sum=30, x_diff=10, valid_out=1, ovf=0.
REQ-032 SCALE=0, a=100, z=50 -> x_sum=127 (saturated), x_diff=50, ovf=1; ovf stays 1 over following clean operation a=1,z=1.
REQ-033 SCALE=0, a=-100, z=50 -> x_sum=-50, x_diff=-128 (saturated), ovf=1.
REQ-034 SCALE=1, a=100, z=50 -> x_sum=75, x_diff=25; a=-3, z=0 -> x_sum=-2, x_diff=-2; ovf=0.
REQ-035 ready_product held 0 for 10 cycles after EN -> stays WAIT_PROD, cycle_finish=0; EN pulses and ack held 0 during OUTPUT -> outputs held, no new capture.
REQ-036 rst pulsed mid-cycle while in CALC -> all outputs 0 before next clk edge, state IDLE, no valid_out after release.

Source files
------------

// File: rtl/butterfly_addsub.sv
// Radix-2 butterfly add/subtract stage: pairs an upper sample with the twiddle
// product from the multiplier stage and produces a+z / a-z with saturate or halve.
module butterfly_addsub #(
    parameter int datalength = 8,
    parameter bit SCALE      = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         EN,
    input  logic signed [datalength-1:0] a,
    input  logic signed [datalength-1:0] z,
    input  logic                         ready_product,
    output logic                         cycle_finish,
    input  logic                         ack,
    output logic signed [datalength-1:0] x_sum,
    output logic signed [datalength-1:0] x_diff,
    output logic                         valid_out,
    output logic                         ovf
);
    localparam int W = datalength;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_PROD = 2'd1,
        CALC      = 2'd2,
        OUTPUT    = 2'd3
    } state_t;

    state_t              state_r;
    logic signed [W-1:0] a_r;
    logic signed [W-1:0] z_r;
    logic        [W:0]   sum_s;
    logic        [W:0]   diff_s;

    // Reduce a W+1-bit result to W bits: halve (floor) when scaling, else clamp.
    function automatic logic [W-1:0] fit_result(input logic [W:0] v);
        logic [W:0] halved;
        halved = {v[W], v[W:1]};
        if (SCALE) begin
            fit_result = halved[W-1:0];
        end else if (v[W] != v[W-1]) begin
            fit_result = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            fit_result = v[W-1:0];
        end
    endfunction

    // A W+1-bit result needs clamping when its top two bits disagree.
    function automatic logic needs_sat(input logic [W:0] v);
        needs_sat = (!SCALE) && (v[W] != v[W-1]);
    endfunction

    // Sign-extended sum and difference of the latched operands.
    always_comb begin
        sum_s  = {a_r[W-1], a_r} + {z_r[W-1], z_r};
        diff_s = {a_r[W-1], a_r} - {z_r[W-1], z_r};
    end

    // Handshake sequencer with registered results and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            a_r          <= {W{1'b0}};
            z_r          <= {W{1'b0}};
            x_sum        <= {W{1'b0}};
            x_diff       <= {W{1'b0}};
            valid_out    <= 1'b0;
            cycle_finish <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (EN) begin
                        a_r     <= a;
                        state_r <= WAIT_PROD;
                    end
                end
                WAIT_PROD: begin
                    if (ready_product) begin
                        z_r          <= z;
                        cycle_finish <= 1'b1;
                        state_r      <= CALC;
                    end
                end
                CALC: begin
                    cycle_finish <= 1'b0;
                    x_sum        <= fit_result(sum_s);
                    x_diff       <= fit_result(diff_s);
                    ovf          <= ovf | needs_sat(sum_s) | needs_sat(diff_s);
                    valid_out    <= 1'b1;
                    state_r      <= OUTPUT;
                end
                OUTPUT: begin
                    if (ack) begin
                        valid_out <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    cycle_finish <= 1'b0;
                    valid_out    <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_butterfly_addsub.sv
// Bench for butterfly_addsub: saturating and scaling instances share stimulus and
// are checked each cycle against an integer protocol model plus literal anchors.
module tb_butterfly_addsub;
    localparam int MAXV = 127;
    localparam int MINV = -128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic EN, ready_product, ack;
    logic signed [7:0] a, z;
    logic cf0, cf1, v0, v1, o0, o1;
    logic signed [7:0] s0, d0, s1, d1;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int   m_phase = 0;
    int   m_a = 0, m_z = 0;
    int   e_s0 = 0, e_d0 = 0, e_s1 = 0, e_d1 = 0;
    logic e_cf = 1'b0, e_v = 1'b0, e_ovf = 1'b0;

    always #5 clk = ~clk;

    butterfly_addsub #(.datalength(8), .SCALE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .EN(EN), .a(a), .z(z), .ready_product(ready_product),
        .cycle_finish(cf0), .ack(ack), .x_sum(s0), .x_diff(d0), .valid_out(v0), .ovf(o0));

    butterfly_addsub #(.datalength(8), .SCALE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .EN(EN), .a(a), .z(z), .ready_product(ready_product),
        .cycle_finish(cf1), .ack(ack), .x_sum(s1), .x_diff(d1), .valid_out(v1), .ovf(o1));

    function automatic int clamp(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic int floor_half(input int v);
        if (v < 0 && (v % 2) != 0) return (v - 1) / 2;
        return v / 2;
    endfunction

    function automatic logic out_of_range(input int v);
        return (v > MAXV) || (v < MINV);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // transaction-level model: idle -> waiting -> computing -> presenting
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_a <= 0; m_z <= 0;
            e_s0 <= 0; e_d0 <= 0; e_s1 <= 0; e_d1 <= 0;
            e_cf <= 1'b0; e_v <= 1'b0; e_ovf <= 1'b0;
        end else begin
            case (m_phase)
                0: if (EN) begin m_a <= int'(a); m_phase <= 1; end
                1: if (ready_product) begin m_z <= int'(z); e_cf <= 1'b1; m_phase <= 2; end
                2: begin
                    e_cf  <= 1'b0;
                    e_s0  <= clamp(m_a + m_z);
                    e_d0  <= clamp(m_a - m_z);
                    e_s1  <= floor_half(m_a + m_z);
                    e_d1  <= floor_half(m_a - m_z);
                    e_ovf <= e_ovf | out_of_range(m_a + m_z) | out_of_range(m_a - m_z);
                    e_v   <= 1'b1;
                    m_phase <= 3;
                end
                3: if (ack) begin e_v <= 1'b0; m_phase <= 0; end
                default: m_phase <= 0;
            endcase
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        chk("cf0", int'(cf0), int'(e_cf));
        chk("cf1", int'(cf1), int'(e_cf));
        chk("valid0", int'(v0), int'(e_v));
        chk("valid1", int'(v1), int'(e_v));
        chk("ovf0", int'(o0), int'(e_ovf));
        chk("ovf1", int'(o1), 0);
        chk("sum0", int'(s0), e_s0);
        chk("diff0", int'(d0), e_d0);
        chk("sum1", int'(s1), e_s1);
        chk("diff1", int'(d1), e_d1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // run an operation up to the presenting phase, checking handshake timing
    task automatic op(input int av, input int zv);
        EN = 1'b1; a = 8'(av);
        tick();
        EN = 1'b0; a = 8'sd0;
        ready_product = 1'b1; z = 8'(zv);
        tick();
        ready_product = 1'b0; z = 8'sd0;
        chk("cf_in_calc", int'(cf0), 1);
        chk("valid_not_yet", int'(v0), 0);
        tick();
        chk("cf_after_calc", int'(cf0), 0);
        chk("valid_latency", int'(v0), 1);
    endtask

    task automatic release_op();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("valid_cleared", int'(v0), 0);
    endtask

    initial begin
        EN = 1'b0; ready_product = 1'b0; ack = 1'b0; a = 8'sd0; z = 8'sd0;
        repeat (3) tick();
        chk("rst_sum", int'(s0), 0);
        chk("rst_valid", int'(v0), 0);
        chk("rst_ovf", int'(o0), 0);
        chk("rst_cf", int'(cf0), 0);
        rst = 1'b0;

        op(20, 10);
        chk("l31_sum", int'(s0), 30);
        chk("l31_diff", int'(d0), 10);
        chk("l31_ovf", int'(o0), 0);
        chk("l31_sum_sc", int'(s1), 15);
        chk("l31_diff_sc", int'(d1), 5);
        release_op();

        op(100, 50);
        chk("l32_sum", int'(s0), 127);
        chk("l32_diff", int'(d0), 50);
        chk("l32_ovf", int'(o0), 1);
        chk("l34_sum_sc", int'(s1), 75);
        chk("l34_diff_sc", int'(d1), 25);
        chk("l34_ovf_sc", int'(o1), 0);
        release_op();
        op(1, 1);
        chk("sticky_sum", int'(s0), 2);
        chk("sticky_diff", int'(d0), 0);
        chk("sticky_ovf", int'(o0), 1);
        release_op();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf_cleared", int'(o0), 0);
        op(-100, 50);
        chk("l33_sum", int'(s0), -50);
        chk("l33_diff", int'(d0), -128);
        chk("l33_ovf", int'(o0), 1);
        chk("l33_sum_sc", int'(s1), -25);
        chk("l33_diff_sc", int'(d1), -75);
        release_op();

        op(-3, 0);
        chk("floor_sum_sc", int'(s1), -2);
        chk("floor_diff_sc", int'(d1), -2);
        chk("floor_ovf_sc", int'(o1), 0);
        chk("neg_sum", int'(s0), -3);
        release_op();

        // product withheld: stay waiting, ignore EN and ack
        EN = 1'b1; a = 8'sd5;
        tick();
        ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            EN = (i % 2) == 0; a = 8'(i * 3 + 40);
            tick();
            chk("wait_cf", int'(cf0), 0);
            chk("wait_valid", int'(v0), 0);
        end
        ack = 1'b0; EN = 1'b0;
        ready_product = 1'b1; z = 8'sd7;
        tick();
        ready_product = 1'b0;
        tick();
        chk("held_sum", int'(s0), 12);
        chk("held_diff", int'(d0), -2);
        for (int i = 0; i < 5; i++) begin
            EN = 1'b1; a = 8'sd99; ready_product = 1'b1; z = 8'sd99;
            tick();
            chk("hold_sum", int'(s0), 12);
            chk("hold_diff", int'(d0), -2);
            chk("hold_valid", int'(v0), 1);
        end
        EN = 1'b0; ready_product = 1'b0; a = 8'sd0; z = 8'sd0;
        release_op();

        // asynchronous reset while computing
        EN = 1'b1; a = 8'sd20;
        tick();
        EN = 1'b0; ready_product = 1'b1; z = 8'sd10;
        tick();
        ready_product = 1'b0;
        chk("pre_rst_cf", int'(cf0), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_cf", int'(cf0), 0);
        chk("arst_sum", int'(s0), 0);
        chk("arst_diff", int'(d0), 0);
        chk("arst_valid", int'(v0), 0);
        chk("arst_sum_sc", int'(s1), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_valid", int'(v0), 0);
            chk("post_rst_cf", int'(cf0), 0);
        end
        op(20, 10);
        chk("recover_sum", int'(s0), 30);
        release_op();
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
